// File: rtl/seqdetect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seqdetect_pkg
// Description : Shared types, default parameters and next-state function for
//               the 111001 frame-level pattern detector.
// Revision    : 1.0 - initial release
// ============================================================================
package seqdetect_pkg;

    localparam int unsigned DEF_WORD_W = 8;
    localparam int unsigned DEF_LEN_W  = 8;
    localparam int unsigned DEF_CNT_W  = 8;
    localparam int unsigned DEF_POS_W  = 16;

    // Detector states: S<n> means n bits of the pattern have been seen,
    // S6 is the matched state.
    typedef enum logic [2:0] {
        DET_S0 = 3'd0,
        DET_S1 = 3'd1,
        DET_S2 = 3'd2,
        DET_S3 = 3'd3,
        DET_S4 = 3'd4,
        DET_S5 = 3'd5,
        DET_S6 = 3'd6
    } det_state_e;

    typedef enum logic [2:0] {
        CTL_IDLE  = 3'd0,
        CTL_WAIT  = 3'd1,
        CTL_SHIFT = 3'd2,
        CTL_DRAIN = 3'd3,
        CTL_DONE  = 3'd4
    } ctl_state_e;

    // Detector transition table. After a match the trailing 1 does not seed
    // a new pattern, so matches never overlap.
    function automatic det_state_e det_next(input det_state_e s, input logic b);
        det_state_e n;
        n = DET_S0;
        case (s)
            DET_S0:  n = b ? DET_S1 : DET_S0;
            DET_S1:  n = b ? DET_S2 : DET_S0;
            DET_S2:  n = b ? DET_S3 : DET_S0;
            DET_S3:  n = b ? DET_S3 : DET_S4;
            DET_S4:  n = b ? DET_S1 : DET_S5;
            DET_S5:  n = b ? DET_S6 : DET_S0;
            DET_S6:  n = b ? DET_S1 : DET_S0;
            default: n = DET_S0;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seqdetect_core.sv
`default_nettype none
// ============================================================================
// Module      : seqdetect_core
// Description : Moore detector for the serial pattern 111001. Advances only
//               on bit_en; hit pulses one cycle after the matching bit.
// Revision    : 1.0 - initial release
// ============================================================================
module seqdetect_core
    import seqdetect_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic bit_en_i,
    input  logic bit_in_i,
    output logic hit_o
);

    det_state_e state_q;
    det_state_e state_d;
    logic       hit_q;

    // Next state for the bit currently presented.
    always_comb begin
        state_d = det_next(state_q, bit_in_i);
    end

    // Advance on enabled bits; hit is registered so it lasts exactly one cycle
    // even when the detector then holds in S6.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DET_S0;
            hit_q   <= 1'b0;
        end else if (clr_i) begin
            state_q <= DET_S0;
            hit_q   <= 1'b0;
        end else if (bit_en_i) begin
            state_q <= state_d;
            hit_q   <= (state_d == DET_S6);
        end else begin
            hit_q   <= 1'b0;
        end
    end

    assign hit_o = hit_q;

endmodule
`default_nettype wire

// File: rtl/seqdetect_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seqdetect_frame_ctrl
// Description : Accepts a frame of words over valid/ready, serialises each
//               word MSB-first into the 111001 detector and reports the match
//               count and first match position with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module seqdetect_frame_ctrl
    import seqdetect_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W,
    parameter int unsigned LEN_W  = DEF_LEN_W,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned POS_W  = DEF_POS_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [LEN_W-1:0]  frame_len_i,
    input  logic [WORD_W-1:0] din_i,
    input  logic              din_valid_i,
    output logic              din_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  match_cnt_o,
    output logic              overflow_o,
    output logic [POS_W-1:0]  first_pos_o,
    output logic              first_valid_o
);

    localparam int unsigned       BIT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(WORD_W - 1);

    ctl_state_e          state_q;
    logic [WORD_W-1:0]   shreg_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [LEN_W-1:0]    words_left_q;
    logic                din_ready_q;
    logic                busy_q;
    logic                done_q;

    logic [CNT_W-1:0]    match_cnt_q;
    logic                overflow_q;
    logic [POS_W-1:0]    first_pos_q;
    logic                first_valid_q;
    logic [POS_W-1:0]    bit_idx_q;

    logic                start_acc;
    logic                abort_act;
    logic                bit_en;
    logic                hit;

    // Abort beats start in IDLE; abort only matters while a frame is active.
    assign start_acc = (state_q == CTL_IDLE) && start_i && !abort_i;
    assign abort_act = abort_i && ((state_q == CTL_WAIT) || (state_q == CTL_SHIFT) ||
                                   (state_q == CTL_DRAIN));
    assign bit_en    = (state_q == CTL_SHIFT) && !abort_i;

    seqdetect_core u_core (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (start_acc),
        .bit_en_i (bit_en),
        .bit_in_i (shreg_q[WORD_W-1]),
        .hit_o    (hit)
    );

    // Frame sequencing: state, shift register, counters and registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= CTL_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            words_left_q <= '0;
            din_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_act) begin
                state_q     <= CTL_IDLE;
                din_ready_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    CTL_IDLE: begin
                        if (start_acc) begin
                            busy_q <= 1'b1;
                            if (frame_len_i != '0) begin
                                words_left_q <= frame_len_i;
                                din_ready_q  <= 1'b1;
                                state_q      <= CTL_WAIT;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= CTL_DONE;
                            end
                        end
                    end
                    CTL_WAIT: begin
                        if (din_valid_i) begin
                            shreg_q     <= din_i;
                            bit_cnt_q   <= '0;
                            din_ready_q <= 1'b0;
                            state_q     <= CTL_SHIFT;
                        end
                    end
                    CTL_SHIFT: begin
                        shreg_q   <= shreg_q << 1;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            words_left_q <= words_left_q - 1'b1;
                            if (words_left_q == LEN_W'(1)) begin
                                state_q <= CTL_DRAIN;
                            end else begin
                                din_ready_q <= 1'b1;
                                state_q     <= CTL_WAIT;
                            end
                        end
                    end
                    CTL_DRAIN: begin
                        // Extra cycle lets the hit from the final bit land.
                        done_q  <= 1'b1;
                        state_q <= CTL_DONE;
                    end
                    CTL_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= CTL_IDLE;
                    end
                    default: begin
                        din_ready_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= CTL_IDLE;
                    end
                endcase
            end
        end
    end

    // Result accounting: cleared on an accepted start, updated on every hit in any state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            match_cnt_q   <= '0;
            overflow_q    <= 1'b0;
            first_pos_q   <= '0;
            first_valid_q <= 1'b0;
            bit_idx_q     <= '0;
        end else if (start_acc) begin
            match_cnt_q   <= '0;
            overflow_q    <= 1'b0;
            first_valid_q <= 1'b0;
            bit_idx_q     <= '0;
        end else begin
            if (bit_en) begin
                bit_idx_q <= bit_idx_q + 1'b1;
            end
            if (hit) begin
                if (match_cnt_q != {CNT_W{1'b1}}) begin
                    match_cnt_q <= match_cnt_q + 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
                if (!first_valid_q) begin
                    // The index has already moved past the bit that completed the match.
                    first_pos_q   <= bit_idx_q - 1'b1;
                    first_valid_q <= 1'b1;
                end
            end
        end
    end

    assign din_ready_o   = din_ready_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign match_cnt_o   = match_cnt_q;
    assign overflow_o    = overflow_q;
    assign first_pos_o   = first_pos_q;
    assign first_valid_o = first_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_seqdetect_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seqdetect_frame_ctrl
// Description : Self-checking bench; two instances (8-bit and 2-bit match
//               counters) share stimulus and are compared against a
//               bit-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seqdetect_frame_ctrl;

    localparam int WW  = 8;
    localparam int LW  = 8;
    localparam int CW  = 8;
    localparam int CW2 = 2;
    localparam int PW  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic [WW-1:0] din = '0;
    logic          din_valid = 1'b0;

    logic           rdy_a, busy_a, done_a, ovf_a, fv_a;
    logic [CW-1:0]  cnt_a;
    logic [PW-1:0]  fpos_a;
    logic           rdy_b, busy_b, done_b, ovf_b, fv_b;
    logic [CW2-1:0] cnt_b;
    logic [PW-1:0]  fpos_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [WW-1:0] words[$];
    int            gaps[$];

    seqdetect_frame_ctrl #(.WORD_W(WW), .LEN_W(LW), .CNT_W(CW), .POS_W(PW)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .frame_len_i(frame_len), .din_i(din), .din_valid_i(din_valid),
        .din_ready_o(rdy_a), .busy_o(busy_a), .done_o(done_a), .match_cnt_o(cnt_a),
        .overflow_o(ovf_a), .first_pos_o(fpos_a), .first_valid_o(fv_a)
    );

    seqdetect_frame_ctrl #(.WORD_W(WW), .LEN_W(LW), .CNT_W(CW2), .POS_W(PW)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .frame_len_i(frame_len), .din_i(din), .din_valid_i(din_valid),
        .din_ready_o(rdy_b), .busy_o(busy_b), .done_o(done_b), .match_cnt_o(cnt_b),
        .overflow_o(ovf_b), .first_pos_o(fpos_b), .first_valid_o(fv_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic bit get_bit(input int i);
        logic [WW-1:0] w;
        w = words[i / WW];
        return w[WW - 1 - (i % WW)];
    endfunction

    // Non-overlapping left-to-right search of 111001 over the first nbits bits.
    task automatic model(input int nbits, output int cnt, output int fpos);
        int i;
        logic [5:0] win;
        cnt  = 0;
        fpos = -1;
        i    = 0;
        while (i + 6 <= nbits) begin
            for (int k = 0; k < 6; k++) win[5-k] = get_bit(i + k);
            if (win == 6'b111001) begin
                cnt++;
                if (fpos < 0) fpos = i + 5;
                i += 6;
            end else begin
                i++;
            end
        end
    endtask

    task automatic check_results(input string tag, input int nbits);
        int cnt, fpos, sat;
        model(nbits, cnt, fpos);
        chk_eq({tag, "_cnt_a"}, 32'(cnt_a), (cnt > 255) ? 255 : cnt);
        chk_eq({tag, "_ovf_a"}, 32'(ovf_a), (cnt > 255) ? 1 : 0);
        sat = (cnt > 3) ? 3 : cnt;
        chk_eq({tag, "_cnt_b"}, 32'(cnt_b), sat);
        chk_eq({tag, "_ovf_b"}, 32'(ovf_b), (cnt > 3) ? 1 : 0);
        chk_eq({tag, "_fv_a"}, 32'(fv_a), (fpos >= 0) ? 1 : 0);
        chk_eq({tag, "_fv_b"}, 32'(fv_b), (fpos >= 0) ? 1 : 0);
        if (fpos >= 0) begin
            chk_eq({tag, "_fpos_a"}, 32'(fpos_a), fpos % 65536);
            chk_eq({tag, "_fpos_b"}, 32'(fpos_b), fpos % 65536);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk_eq({tag, "_rdy"},  {30'd0, rdy_a, rdy_b}, 0);
        chk_eq({tag, "_busy"}, {30'd0, busy_a, busy_b}, 0);
        chk_eq({tag, "_done"}, {30'd0, done_a, done_b}, 0);
        chk_eq({tag, "_cnt"},  {22'd0, cnt_a, cnt_b}, 0);
        chk_eq({tag, "_flags"}, {28'd0, ovf_a, ovf_b, fv_a, fv_b}, 0);
        chk_eq({tag, "_fpos"}, {fpos_a, fpos_b}, 0);
    endtask

    // Waits (bounded) for din_ready, idles gap cycles, then presents one word.
    task automatic send_word(input string tag, input logic [WW-1:0] w, input int gap);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (rdy_a && rdy_b) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk_eq({tag, "_ready"}, 32'(ok), 1);
        repeat (gap) begin @(posedge clk); #1; end
        din       = w;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        din       = WW'($urandom);
    endtask

    task automatic run_frame(input string tag, input int len);
        int c0, g_tot, exp_done;
        bit seen;
        @(posedge clk); #1;
        c0        = cyc;
        start     = 1'b1;
        frame_len = LW'(len);
        @(posedge clk); #1;
        start = 1'b0;
        chk_eq({tag, "_busy"}, {30'd0, busy_a, busy_b}, 3);
        g_tot = 0;
        for (int w = 0; w < len; w++) begin
            send_word(tag, words[w], gaps[w]);
            g_tot += gaps[w];
        end
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (done_a) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk_eq({tag, "_done"}, {30'd0, done_a, done_b}, 3);
        exp_done = (len == 0) ? c0 + 1 : c0 + 2 + 9 * len + g_tot;
        chk_eq({tag, "_done_cyc"}, 32'(cyc), 32'(exp_done));
        check_results(tag, len * WW);
        @(posedge clk); #1;
        chk_eq({tag, "_done_end"}, {30'd0, done_a, done_b}, 0);
        chk_eq({tag, "_idle"}, {30'd0, busy_a, busy_b}, 0);
    endtask

    task automatic load(input logic [WW-1:0] w, input int gap);
        words.push_back(w);
        gaps.push_back(gap);
    endtask

    task automatic clear_frame();
        words.delete();
        gaps.delete();
    endtask

    initial begin : main
        logic [WW-1:0] pool [8];
        logic [5:0]    pat;
        logic [WW-1:0] w;
        int            len;
        bit            seen;

        pool = '{8'hE4, 8'h07, 8'h20, 8'h39, 8'h9C, 8'hE7, 8'hFF, 8'h00};
        pat  = 6'b111001;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        clear_frame(); load(8'hE4, 0);
        run_frame("t1", 1);
        chk_eq("t1_lit_cnt", 32'(cnt_a), 1);
        chk_eq("t1_lit_pos", 32'(fpos_a), 5);

        clear_frame(); load(8'h07, 0); load(8'h20, 0);
        run_frame("t2", 2);
        chk_eq("t2_lit_pos", 32'(fpos_a), 10);

        clear_frame(); load(8'hE4, 0); load(8'hE4, 0);
        run_frame("t3", 2);
        clear_frame(); load(8'hE4, 0); load(8'hE4, 5);
        run_frame("t3gap", 2);
        chk_eq("t3gap_lit_cnt", 32'(cnt_a), 2);

        clear_frame();
        run_frame("t4", 0);

        clear_frame(); repeat (4) load(8'hE4, 0);
        run_frame("t5", 4);
        chk_eq("t5_lit_cnt_b", 32'(cnt_b), 3);
        chk_eq("t5_lit_ovf_b", 32'(ovf_b), 1);

        for (int f = 0; f < 30; f++) begin
            clear_frame();
            len = $urandom_range(0, 6);
            for (int k = 0; k < len; k++) begin
                w = ($urandom_range(0, 3) == 0) ? WW'($urandom) : pool[$urandom_range(0, 7)];
                load(w, $urandom_range(0, 3));
            end
            run_frame($sformatf("rnd%0d", f), len);
        end

        clear_frame(); repeat (255) load(8'hE4, 0);
        run_frame("maxlen", 255);

        clear_frame();
        for (int k = 0; k < 255; k++) begin
            for (int b = 0; b < WW; b++) w[WW-1-b] = pat[5 - ((k * WW + b) % 6)];
            load(w, 0);
        end
        run_frame("dense", 255);

        // Abort two bits into the second word.
        clear_frame(); load(8'hE4, 0); load(8'hE4, 0);
        @(posedge clk); #1;
        start = 1'b1; frame_len = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        send_word("abt", 8'hE4, 0);
        send_word("abt", 8'hE4, 0);
        repeat (2) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk_eq("abt_busy", {30'd0, busy_a, busy_b}, 0);
        chk_eq("abt_rdy", {30'd0, rdy_a, rdy_b}, 0);
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (done_a || done_b) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk_eq("abt_nodone", 32'(seen), 0);
        check_results("abt", 10);
        chk_eq("abt_lit_cnt", 32'(cnt_a), 1);

        // Reset in the middle of a frame.
        @(posedge clk); #1;
        start = 1'b1; frame_len = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        send_word("mrst", 8'hE4, 0);
        repeat (8) begin @(posedge clk); #1; end
        chk_eq("mrst_pre_cnt", 32'(cnt_a), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_frame(); load(8'hE4, 0);
        run_frame("t1b", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
